mem_bus_arbiter: RTL and testbench

Two-port memory bus arbiter and sequencer that shares the single test RAM between the 65c816 CPU core (port 0) and a second bus master such as a program loader or debug DMA (port 1). Each master runs a request/done handshake. The block latches the winning request, drives the RAM address/write-enable/data, waits for the RAM's `data_ready`, and returns read data with a one-cycle completion pulse. A timeout aborts accesses the RAM never completes. It sits between `Cpu`/loader and `TestRam`, replacing the direct wire-up in the bench.

---
 rtl/mem_bus_arbiter_pkg.sv | 30 +++
 rtl/mem_arb_rr_pick.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port memory bus arbiter: FSM encodings,
// port indices and the read/write encoding used by the CPU core.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Port 0 is the 65c816 core, port 1 the loader / debug DMA master.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Matches the CPU's which_rdwr encoding: 0 = read, 1 = write.
  typedef enum logic {
    RDWR_READ  = 1'b0,
    RDWR_WRITE = 1'b1
  } rdwr_e;

  // Timeout counter width; compared for equality only.
  localparam int CNT_W = 8;

  // Per-port one-hot strobe for the granted port index.
  function automatic logic [1:0] port_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker. Holds last_grant; on a tie the port that did
// not win last time gets the bus. last_grant resets to the aux port so the
// CPU wins the first tie after reset.
module mem_arb_rr_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_idx,
  output logic       gnt_vld
);

  logic last_grant_q, last_grant_d;

  // Winner selection: single requester wins outright, tie goes to the other port.
  always_comb begin
    gnt_vld = |req;
    if (&req)
      gnt_idx = ~last_grant_q;
    else if (req[PORT_CPU])
      gnt_idx = PORT_CPU;
    else
      gnt_idx = PORT_AUX;
  end

  // Remember the winner only when a grant is actually taken.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_en && gnt_vld)
      last_grant_d = gnt_idx;
  end

  // last_grant register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= PORT_AUX;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter / sequencer in front of the shared test RAM.
// IDLE picks and latches a request, ISSUE drives it for one cycle (write
// strobe here only), WAIT polls data_ready with a timeout, DONE pulses the
// per-port done/err strobe for one cycle.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            done,
  output logic [1:0]            err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_data_ready
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e            state_q, state_d;
  logic                  port_q, port_d;
  rdwr_e                 we_q, we_d;
  logic                  err_flag_q, err_flag_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;

  logic                  gnt_idx, gnt_vld, grant_en;

  mem_arb_rr_pick u_pick (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant_en (grant_en),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld)
  );

  // Next-state logic: latch on grant, count WAIT cycles, capture read data.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_flag_d = err_flag_q;
    cnt_d      = cnt_q;
    grant_en   = 1'b0;
    cnt_inc    = cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        grant_en = 1'b1;
        if (gnt_vld) begin
          port_d  = gnt_idx;
          we_d    = rdwr_e'(we[gnt_idx]);
          addr_d  = gnt_idx ? addr1 : addr0;
          wdata_d = gnt_idx ? wdata1 : wdata0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Ready during ISSUE is deliberately not looked at.
        cnt_d      = '0;
        err_flag_d = 1'b0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (ram_data_ready) begin
          // Captured for writes too; the RAM's output is what it is.
          rdata_d    = ram_data_out;
          err_flag_d = 1'b0;
          state_d    = ST_DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          rdata_d    = '1;
          err_flag_d = 1'b1;
          cnt_d      = cnt_inc;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      port_q     <= PORT_CPU;
      we_q       <= RDWR_READ;
      err_flag_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      we_q       <= we_d;
      err_flag_q <= err_flag_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Strobes decode straight from state so reset kills them immediately.
  always_comb begin
    done   = 2'b00;
    err    = 2'b00;
    ram_we = 1'b0;
    if (state_q == ST_ISSUE)
      ram_we = (we_q == RDWR_WRITE);
    if (state_q == ST_DONE) begin
      if (err_flag_q) err  = port_onehot(port_q);
      else            done = port_onehot(port_q);
    end
  end

  assign ram_addr    = addr_q;
  assign ram_data_in = wdata_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int AW = 24;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [1:0]    we  = 2'b00;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [DW-1:0] ram_data_out = '0;
  logic          ram_data_ready = 1'b0;
  logic [1:0]    done, err;
  logic [DW-1:0] rdata, ram_data_in;
  logic          ram_we;
  logic [AW-1:0] ram_addr;

  int n_pass  = 0;
  int n_total = 0;

  // Model: one outstanding transaction, its age in cycles since grant
  // (1 = issue cycle, 2.. = waiting), and how it finished (1 done, 2 timeout).
  bit            m_busy;
  int            m_age;
  int            m_fin;
  int            m_port;
  int            m_last;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0]    pf;       // per-port finish strobe of the cycle just ended

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .err(err), .rdata(rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_data_ready(ram_data_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic reset_model();
    m_busy = 0; m_age = 0; m_fin = 0; m_port = 0; m_last = 1; m_we = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; pf = 2'b00;
  endtask

  // Advance the model by one clock using the inputs of the cycle that ended.
  task automatic model_step();
    int w;
    if (m_fin != 0) begin
      m_fin = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (req != 2'b00) begin
        if (req == 2'b11) w = 1 - m_last;
        else              w = req[0] ? 0 : 1;
        m_last = w; m_port = w; m_we = we[w];
        m_addr  = (w == 1) ? addr1 : addr0;
        m_wdata = (w == 1) ? wdata1 : wdata0;
        m_busy = 1; m_age = 1;
      end
    end else if (m_age >= 2 && ram_data_ready) begin
      m_rdata = ram_data_out; m_fin = 1;
    end else if (m_age >= 2 && (m_age - 1) == TO) begin
      m_rdata = '1; m_fin = 2;
    end else begin
      m_age++;
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    pf = 2'b00;
    if (m_fin != 0) pf[m_port] = 1'b1;
    if (!rst) model_step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reset_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic new_fields(input int p);
    we[p] = 1'($urandom_range(0, 1));
    if (p == 0) begin addr0 = AW'($urandom); wdata0 = DW'($urandom); end
    else        begin addr1 = AW'($urandom); wdata1 = DW'($urandom); end
  endtask

  task automatic drive_port(input int p);
    if (req[p]) begin
      if (pf[p]) begin
        if ($urandom_range(0, 2) == 0) req[p] = 1'b0;
        else new_fields(p);
      end else if ($urandom_range(0, 3) == 0) begin
        new_fields(p);
      end
    end else if ($urandom_range(0, 3) == 0) begin
      req[p] = 1'b1;
      new_fields(p);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    logic [1:0] ed, ee;
    logic       ew;
    ed = 2'b00; ee = 2'b00;
    if (m_fin == 1) ed[m_port] = 1'b1;
    if (m_fin == 2) ee[m_port] = 1'b1;
    ew = m_busy && m_fin == 0 && m_age == 1 && m_we;
    chk("done", 32'(done), 32'(ed));
    chk("err", 32'(err), 32'(ee));
    chk("ram_we", 32'(ram_we), 32'(ew));
    chk("ram_addr", 32'(ram_addr), 32'(m_addr));
    chk("ram_data_in", 32'(ram_data_in), 32'(m_wdata));
    if ((ed | ee) != 2'b00 || rst) chk("rdata", 32'(rdata), 32'(m_rdata));
  end

  initial begin
    logic [1:0] seq [$];
    reset_model();
    do_reset();
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_data_in", 32'(ram_data_in), 32'h0);

    // Single read on port 0, ready in the first WAIT cycle.
    req = 2'b01; we = 2'b00; addr0 = 24'h000010;
    cycle(); chk("rd_issue_we", 32'(ram_we), 32'h0); chk("rd_issue_addr", 32'(ram_addr), 32'h10);
    cycle(); ram_data_ready = 1'b1; ram_data_out = 8'hA5;
    cycle(); chk("rd_done", 32'(done), 32'h1); chk("rd_rdata", 32'(rdata), 32'hA5);
    chk("model_rd_rdata", 32'(m_rdata), 32'hA5);
    req = 2'b00; ram_data_ready = 1'b0;
    cycle();

    // Single write on port 1; early ready during ISSUE must be ignored.
    req = 2'b10; we = 2'b10; addr1 = 24'h001234; wdata1 = 8'h5A;
    cycle(); chk("wr_issue_we", 32'(ram_we), 32'h1);
    chk("wr_issue_addr", 32'(ram_addr), 32'h1234); chk("wr_issue_data", 32'(ram_data_in), 32'h5A);
    ram_data_ready = 1'b1; ram_data_out = 8'h33;
    cycle(); chk("wr_wait_we", 32'(ram_we), 32'h0); ram_data_ready = 1'b0;
    cycle(); chk("wr_no_early_done", 32'(done), 32'h0); ram_data_ready = 1'b1; ram_data_out = 8'h44;
    cycle(); chk("wr_done", 32'(done), 32'h2); chk("wr_rdata", 32'(rdata), 32'h44);
    req = 2'b00; we = 2'b00; ram_data_ready = 1'b0;
    cycle();

    // Timeout on port 0 read: err at cycle 2+TO.
    req = 2'b01; addr0 = 24'h00ABCD;
    for (int i = 1; i <= TO + 1; i++) begin
      cycle(); chk("to_quiet", 32'({done, err}), 32'h0);
    end
    cycle(); chk("to_err", 32'(err), 32'h1); chk("to_rdata", 32'(rdata), 32'hFF);
    chk("to_nodone", 32'(done), 32'h0);
    req = 2'b00;
    cycle();
    req = 2'b01; addr0 = 24'h000077;
    cycle(); cycle(); ram_data_ready = 1'b1; ram_data_out = 8'h3C;
    cycle(); chk("post_to_done", 32'(done), 32'h1); chk("post_to_rdata", 32'(rdata), 32'h3C);
    req = 2'b00; ram_data_ready = 1'b0;
    cycle();

    // Contention from reset: both held, grants must alternate 0,1,0,1...
    do_reset();
    req = 2'b11; we = 2'b00; addr0 = 24'h000100; addr1 = 24'h000200; ram_data_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      cycle();
      ram_data_out = DW'($urandom);
      if (done != 2'b00) seq.push_back(done);
    end
    req = 2'b00; ram_data_ready = 1'b0;
    chk("cont_count", 32'(seq.size()), 32'd20);
    for (int k = 0; k < seq.size(); k++)
      chk("cont_order", 32'(seq[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
    chk("model_last_grant", 32'(m_last), 32'd1);
    cycle(); cycle();

    // Reset during ISSUE of a port-0 write.
    req = 2'b01; we = 2'b01; addr0 = 24'h0055AA; wdata0 = 8'h77; addr1 = 24'h000999;
    cycle();
    #1 chk("mid_issue_we", 32'(ram_we), 32'h1);
    rst = 1'b1; reset_model();
    #1 chk("mid_rst_we_drop", 32'(ram_we), 32'h0);
    chk("mid_rst_done", 32'({done, err}), 32'h0);
    req = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cycle(); chk("post_rst_tie_addr", 32'(ram_addr), 32'h55AA); chk("post_rst_tie_we", 32'(ram_we), 32'h1);
    ram_data_ready = 1'b1;
    cycle();
    cycle(); chk("post_rst_done", 32'(done), 32'h1);
    req = 2'b00; we = 2'b00; ram_data_ready = 1'b0;
    cycle();

    // Randomized traffic with occasional ready-starved windows.
    for (int c = 0; c < 3000; c++) begin
      cycle();
      for (int p = 0; p < 2; p++) drive_port(p);
      if (c >= 300 && (c % 500) < 40) ram_data_ready = 1'b0;
      else ram_data_ready = ($urandom_range(0, 3) == 0);
      ram_data_out = DW'($urandom);
    end
    req = 2'b00; ram_data_ready = 1'b1;
    repeat (30) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
